// File: rtl/shared_addsub_arbiter.sv
// Purpose: round-robin sharing of one 2-bit add/sub unit between two requesters.
// Latency: ack rises SETTLE_CYC cycles after the grant edge; one transaction takes SETTLE_CYC+1 cycles.
// Backpressure: a requester holds req until its ack; the loser of arbitration waits. Optional stats: SHARED_ARB_STATS_EN.
module shared_addsub_arbiter #(
  parameter int SETTLE_CYC = 2,    // legal range 1..15
  parameter bit FIRST_PRI  = 1'b0  // wins the first contested arbitration after reset
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [1:0] op0_a,
  input  logic [1:0] op0_b,
  input  logic       mode0,
  input  logic       req1,
  input  logic [1:0] op1_a,
  input  logic [1:0] op1_b,
  input  logic       mode1,
  output logic       ack0,
  output logic       ack1,
  output logic [1:0] res,
  output logic       res_src,
  output logic       busy,
  output logic       sh_a,
  output logic       sh_b,
  output logic       sh_c,
  output logic       sh_d,
  output logic       sh_m,
  input  logic       sh_s1,
  input  logic       sh_s0
`ifdef SHARED_ARB_STATS_EN
  ,
  output logic [7:0] gcnt0,
  output logic [7:0] gcnt1
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       gid, gid_nxt;
  logic       last_srv, last_nxt;
  logic       grant_vld, grant_id, sample;
  logic [4:0] sh_nxt;
  logic       ack0_nxt, ack1_nxt;
  logic [1:0] res_nxt;
  logic       src_nxt;

  // busy comes straight from the state register, so it is registered too
  assign busy = (state != IDLE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state plus the grant/sample decision; DONE ignores the just-served requester
  always_comb begin
    state_nxt = state;
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    sample    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_vld = 1'b1;
          grant_id  = (req0 && req1) ? ~last_srv : req1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == 4'd0) begin
          sample    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        grant_id  = ~gid;
        grant_vld = gid ? req0 : req1;
        state_nxt = grant_vld ? DRIVE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // next values of the registered outputs and datapath state
  always_comb begin
    sh_nxt   = {sh_a, sh_b, sh_c, sh_d, sh_m};
    cnt_nxt  = cnt;
    gid_nxt  = gid;
    last_nxt = last_srv;
    ack0_nxt = 1'b0;
    ack1_nxt = 1'b0;
    res_nxt  = res;
    src_nxt  = res_src;
    if (grant_vld) begin
      sh_nxt  = grant_id ? {op1_a, op1_b, mode1} : {op0_a, op0_b, mode0};
      cnt_nxt = CNT_LOAD;
      gid_nxt = grant_id;
    end else if (state == DONE) begin
      sh_nxt = 5'd0;
    end
    if (state == DRIVE) begin
      if (sample) begin
        res_nxt  = {sh_s1, sh_s0};
        src_nxt  = gid;
        ack0_nxt = ~gid;
        ack1_nxt = gid;
        last_nxt = gid;
      end else begin
        cnt_nxt = cnt - 4'd1;
      end
    end
  end

  // output and datapath registers; reset drops any in-flight transaction silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {sh_a, sh_b, sh_c, sh_d, sh_m} <= 5'd0;
      cnt      <= 4'd0;
      gid      <= 1'b0;
      last_srv <= ~FIRST_PRI;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      res      <= 2'd0;
      res_src  <= 1'b0;
    end else begin
      {sh_a, sh_b, sh_c, sh_d, sh_m} <= sh_nxt;
      cnt      <= cnt_nxt;
      gid      <= gid_nxt;
      last_srv <= last_nxt;
      ack0     <= ack0_nxt;
      ack1     <= ack1_nxt;
      res      <= res_nxt;
      res_src  <= src_nxt;
    end
  end

`ifdef SHARED_ARB_STATS_EN
  // saturating per-requester ack counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt0 <= 8'd0;
      gcnt1 <= 8'd0;
    end else begin
      if (ack0_nxt && gcnt0 != 8'hFF) gcnt0 <= gcnt0 + 8'd1;
      if (ack1_nxt && gcnt1 != 8'hFF) gcnt1 <= gcnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: doc/shared_addsub_arbiter.md
Name: shared_addsub_arbiter

Overview:
Round-robin controller that shares one 2-bit add/sub unit (`shared`: inputs a,b,c,d,m; outputs s1,s0) between two requesters.
- Latches the granted requester's operands and drives them onto the unit.
- Holds the drive for a fixed settle time, then samples the result and returns it with a one-cycle ack.
- Sits between the lab's operand sources and the `shared` instance.
- Unit contract: {s1,s0} = m ? ({a,b} − {c,d}) mod 4 : ({a,b} + {c,d}) mod 4.

Parameters:
SETTLE_CYC, 2, cycles operands are held on the unit before sampling; legal range 1..15.
FIRST_PRI, 0, requester that wins the first contested arbitration after reset (0 or 1).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 request; held until ack0
op0_a  input  2  requester 0 operand A
op0_b  input  2  requester 0 operand B
mode0  input  1  requester 0 mode, 0=add, 1=sub
req1  input  1  requester 1 request
op1_a  input  2  requester 1 operand A
op1_b  input  2  requester 1 operand B
mode1  input  1  requester 1 mode
ack0  output  1  one-cycle pulse, requester 0 result valid on res
ack1  output  1  one-cycle pulse, requester 1 result valid on res
res  output  2  last sampled result
res_src  output  1  requester that owns res
busy  output  1  high when state is not IDLE
sh_a, sh_b  output  1 each  operand A MSB, LSB to the unit
sh_c, sh_d  output  1 each  operand B MSB, LSB to the unit
sh_m  output  1  mode to the unit
sh_s1, sh_s0  input  1 each  unit result MSB, LSB

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - ack0, ack1, res, res_src, busy and all sh_* outputs are 0.
  - Settle counter is 0.
  - last-served pointer = ~FIRST_PRI.
  - Any in-flight transaction is dropped with no ack.
- All outputs are registered; no combinational path from req*/sh_s* to any output.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - If any req is high at a clock edge, grant and go to DRIVE.
  - One requester: grant it.
  - Both requesters: grant the one not equal to last-served.
  - On grant: latch op_a, op_b and mode into sh_a..sh_m, latch the grant id, load counter = SETTLE_CYC−1.
- DRIVE:
  - sh_* are stable for exactly SETTLE_CYC cycles.
  - Counter decrements each edge.
  - At the edge where counter = 0: res <= {sh_s1,sh_s0}, res_src <= grant id, ack of the granted requester <= 1, last-served <= grant id, go to DONE.
- DONE (one cycle):
  - ack is high for this cycle only.
  - The just-served requester's req is ignored this cycle (stale request).
  - If the other requester's req is high: grant it directly (DONE→DRIVE, no idle gap) with the same latch/load actions as IDLE.
  - Otherwise go to IDLE and clear sh_* to 0.
- Latency: grant edge to ack-high cycle = SETTLE_CYC cycles; a transaction occupies SETTLE_CYC+1 cycles.
- Operands are latched at grant. Changes to op*/mode*/req* after grant do not affect the transaction in flight, and it still completes with ack.
- res and res_src hold their value until the next DONE.
- busy = (state != IDLE).

Optional Feature:
SHARED_ARB_STATS_EN:
- Defined: adds output ports gcnt0[7:0] and gcnt1[7:0], reset to 0.
- Each counter increments by 1 on each ack of its requester and saturates at 255 (no wrap).
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
1. Hold rst_n=0 for 3 cycles, then release -> all outputs 0, busy=0; with no req, outputs stay 0 for 10 cycles.
2. SETTLE_CYC=2; req0 with A=3, B=2, mode0=0 -> ack0 high exactly 1 cycle, 2 cycles after grant edge; res=2'b01, res_src=0; sh_a..sh_m = 1,1,1,0,0 during DRIVE.
3. req1 with A=1, B=2, mode1=1 -> ack1 pulse; res=2'b11, res_src=1; ack0 stays 0 throughout.
4. req0 and req1 held high from reset with FIRST_PRI=0 -> grants 0,1,0,1; DONE→DRIVE with no IDLE cycle; busy stays 1; ack spacing = 3 cycles.
5. rst_n=0 mid-DRIVE -> sh_*, busy and ack go to 0 immediately with no ack; after release with both req high, requester FIRST_PRI is served first.
6. With SHARED_ARB_STATS_EN defined, 300 req0-only transactions -> gcnt0=255, gcnt1=0; compiled without the macro the bench builds without gcnt ports.
